// File: rtl/register_word_loader_pkg.sv
// Shared types and parameter-derived helpers for the byte-to-word loader.
// Helpers take plain ints so both the top and the idle timer can size themselves.
package register_word_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } loader_state_e;

    function automatic int calc_bytes(input int wordWidth, input int byteWidth);
        return wordWidth / byteWidth;
    endfunction

    // Needs to hold values 0..BYTES inclusive.
    function automatic int calc_count_width(input int bytes);
        return (bytes < 1) ? 1 : $clog2(bytes + 1);
    endfunction

    function automatic int calc_timer_width(input int timeoutCycles);
        return (timeoutCycles < 1) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

    function automatic int slot_offset(input int slot, input int bytes,
                                       input int byteWidth, input bit lsbFirst);
        return lsbFirst ? (slot * byteWidth) : ((bytes - 1 - slot) * byteWidth);
    endfunction

endpackage

// File: rtl/register_word_loader_idle_timer.sv
// Saturating idle-cycle counter; expired_o flags that the current idle cycle is
// the TIMEOUT_CYCLES-th in a row. A TIMEOUT_CYCLES of 0 never expires.
module loader_idle_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_WIDTH    = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic increment_i,
    output logic expired_o
);

    localparam logic [TIMER_WIDTH-1:0] LIMIT =
        TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (increment_i && (count_q != LIMIT)) begin
            count_d = count_q + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/register_word_loader.sv
// Assembles a valid/ready byte stream into words and hands each finished word to
// the downstream register with a single-cycle enable pulse.
module register_word_loader
    import register_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter bit LSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  hold,
    output logic [WORD_WIDTH-1:0] value_out,
    output logic                  enable_out,
    output logic [calc_count_width(calc_bytes(WORD_WIDTH, BYTE_WIDTH))-1:0] byte_count,
    output logic                  timeout_error
);

    localparam int BYTES = calc_bytes(WORD_WIDTH, BYTE_WIDTH);
    localparam int CW    = calc_count_width(BYTES);
    localparam int TW    = calc_timer_width(TIMEOUT_CYCLES);
    localparam int OW    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    loader_state_e         state_q;
    logic [WORD_WIDTH-1:0] buffer_q;
    logic [WORD_WIDTH-1:0] value_q;
    logic [CW-1:0]         count_q;
    logic                  enable_q;
    logic                  timeout_q;

    logic                  accept;
    logic                  lastSlot;
    logic                  timerClear;
    logic                  timerIncrement;
    logic                  timerExpired;
    logic [OW-1:0]         writeOffset;

    assign byte_ready = (state_q != EMIT);
    assign accept     = byte_valid && byte_ready;
    assign lastSlot   = (count_q == CW'(BYTES - 1));

    // Only COLLECT idles count toward the timeout; any accept restarts the wait.
    assign timerClear     = (state_q != COLLECT) || accept;
    assign timerIncrement = (state_q == COLLECT) && !accept;

    always_comb begin
        writeOffset = OW'(slot_offset((state_q == COLLECT) ? int'(count_q) : 0,
                                      BYTES, BYTE_WIDTH, LSB_FIRST));
    end

    loader_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TW)
    ) u_idle_timer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (timerClear),
        .increment_i (timerIncrement),
        .expired_o   (timerExpired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            buffer_q  <= '0;
            value_q   <= '0;
            count_q   <= '0;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        buffer_q[writeOffset +: BYTE_WIDTH] <= byte_in;
                        count_q <= CW'(1);
                        state_q <= (BYTES == 1) ? EMIT : COLLECT;
                    end
                end
                COLLECT: begin
                    // An accept on the expiry cycle takes precedence over the abort.
                    if (accept) begin
                        buffer_q[writeOffset +: BYTE_WIDTH] <= byte_in;
                        count_q <= count_q + CW'(1);
                        if (lastSlot) begin
                            state_q <= EMIT;
                        end
                    end else if (timerExpired) begin
                        buffer_q  <= '0;
                        count_q   <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                EMIT: begin
                    if (!hold) begin
                        value_q  <= buffer_q;
                        enable_q <= 1'b1;
                        count_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign value_out     = value_q;
    assign enable_out    = enable_q;
    assign byte_count    = count_q;
    assign timeout_error = timeout_q;

endmodule

// File: tb/tb_register_word_loader.sv
// Directed bench for register_word_loader: one LSB-first and one MSB-first
// instance driven by the same byte stream, checked against hand-computed words.
module tb_register_word_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        hold;

    logic        byteReady;
    logic [31:0] valueOut;
    logic        enableOut;
    logic [2:0]  byteCount;
    logic        timeoutError;

    logic        byteReadyMsb;
    logic [31:0] valueOutMsb;
    logic        enableOutMsb;
    logic [2:0]  byteCountMsb;
    logic        timeoutErrorMsb;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    register_word_loader #(
        .WORD_WIDTH     (32),
        .BYTE_WIDTH     (8),
        .LSB_FIRST      (1'b1),
        .TIMEOUT_CYCLES (16)
    ) dutLsb (
        .clock         (clock),
        .reset         (reset),
        .byte_in       (byteIn),
        .byte_valid    (byteValid),
        .byte_ready    (byteReady),
        .hold          (hold),
        .value_out     (valueOut),
        .enable_out    (enableOut),
        .byte_count    (byteCount),
        .timeout_error (timeoutError)
    );

    register_word_loader #(
        .WORD_WIDTH     (32),
        .BYTE_WIDTH     (8),
        .LSB_FIRST      (1'b0),
        .TIMEOUT_CYCLES (16)
    ) dutMsb (
        .clock         (clock),
        .reset         (reset),
        .byte_in       (byteIn),
        .byte_valid    (byteValid),
        .byte_ready    (byteReadyMsb),
        .hold          (hold),
        .value_out     (valueOutMsb),
        .enable_out    (enableOutMsb),
        .byte_count    (byteCountMsb),
        .timeout_error (timeoutErrorMsb)
    );

    // Every comparison goes through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        byteIn    = value;
        byteValid = 1'b1;
        tick();
        byteValid = 1'b0;
    endtask

    task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(b0);
        applyStimulus(b1);
        applyStimulus(b2);
        applyStimulus(b3);
    endtask

    // Called right after the final byte is accepted, with hold low.
    task automatic expectWord(input string tag, input logic [31:0] expected);
        checkOutput({tag, "_readyLowInEmit"}, 32'(byteReady), 32'd0);
        checkOutput({tag, "_countFull"}, 32'(byteCount), 32'd4);
        checkOutput({tag, "_noEarlyPulse"}, 32'(enableOut), 32'd0);
        tick();
        checkOutput({tag, "_pulse"}, 32'(enableOut), 32'd1);
        checkOutput({tag, "_value"}, valueOut, expected);
        checkOutput({tag, "_countCleared"}, 32'(byteCount), 32'd0);
        tick();
        checkOutput({tag, "_pulseEnd"}, 32'(enableOut), 32'd0);
    endtask

    initial begin
        logic [7:0]  stream [8];
        logic [31:0] seen [2];
        int          idx;
        int          lowCycles;
        int          pulses;
        int          run;
        int          maxRun;
        int          pulseCycle [2];
        logic        readyBefore;
        int          timeoutPulses;
        int          timeoutEdge;

        reset     = 1'b1;
        byteIn    = 8'h00;
        byteValid = 1'b0;
        hold      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_value", valueOut, 32'd0);
        checkOutput("rst_enable", 32'(enableOut), 32'd0);
        checkOutput("rst_count", 32'(byteCount), 32'd0);
        checkOutput("rst_timeout", 32'(timeoutError), 32'd0);
        checkOutput("rst_ready", 32'(byteReady), 32'd1);

        $display("[TB] single word 0x1F");
        sendBytes(8'h1F, 8'h00, 8'h00, 8'h00);
        expectWord("word31", 32'd31);

        $display("[TB] streaming two words with valid held high");
        stream    = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h03, 8'h00, 8'h00};
        idx       = 0;
        lowCycles = 0;
        pulses    = 0;
        run       = 0;
        maxRun    = 0;
        seen      = '{32'd0, 32'd0};
        pulseCycle = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            byteValid   = (idx < 8);
            byteIn      = (idx < 8) ? stream[idx] : 8'h00;
            readyBefore = byteReady;
            if (!readyBefore) lowCycles++;
            tick();
            if (readyBefore && (idx < 8)) idx++;
            if (enableOut) begin
                if (pulses < 2) begin
                    seen[pulses]       = valueOut;
                    pulseCycle[pulses] = c;
                end
                pulses++;
                run++;
            end else begin
                run = 0;
            end
            if (run > maxRun) maxRun = run;
        end
        byteValid = 1'b0;
        checkOutput("stream_allAccepted", 32'(idx), 32'd8);
        checkOutput("stream_readyLowCycles", 32'(lowCycles), 32'd2);
        checkOutput("stream_pulses", 32'(pulses), 32'd2);
        checkOutput("stream_pulseWidth", 32'(maxRun), 32'd1);
        checkOutput("stream_word0", seen[0], 32'd127);
        checkOutput("stream_word1", seen[1], 32'd1023);
        checkOutput("stream_spacing", 32'(pulseCycle[1] - pulseCycle[0]), 32'd5);

        $display("[TB] hold in EMIT");
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        hold = 1'b1;
        applyStimulus(8'h44);
        byteIn    = 8'h99;
        byteValid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            checkOutput("hold_ready", 32'(byteReady), 32'd0);
            checkOutput("hold_enable", 32'(enableOut), 32'd0);
            checkOutput("hold_value", valueOut, 32'd1023);
            tick();
        end
        checkOutput("hold_countStable", 32'(byteCount), 32'd4);
        byteValid = 1'b0;
        hold      = 1'b0;
        tick();
        checkOutput("release_pulse", 32'(enableOut), 32'd1);
        checkOutput("release_value", valueOut, 32'h44332211);
        tick();
        checkOutput("release_pulseEnd", 32'(enableOut), 32'd0);

        $display("[TB] idle timeout on partial word");
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        checkOutput("partial_count", 32'(byteCount), 32'd2);
        timeoutPulses = 0;
        timeoutEdge   = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (timeoutError) begin
                timeoutPulses++;
                if (timeoutEdge == 0) timeoutEdge = e;
            end
        end
        checkOutput("timeout_pulses", 32'(timeoutPulses), 32'd1);
        checkOutput("timeout_afterSixteenIdle",
                    32'((timeoutEdge >= 16) && (timeoutEdge <= 17)), 32'd1);
        checkOutput("timeout_count", 32'(byteCount), 32'd0);
        checkOutput("timeout_valueKept", valueOut, 32'h44332211);
        sendBytes(8'h01, 8'h02, 8'h03, 8'h04);
        expectWord("postTimeout", 32'h04030201);

        $display("[TB] reset mid-word");
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        applyStimulus(8'h30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midRst_value", valueOut, 32'd0);
        checkOutput("midRst_enable", 32'(enableOut), 32'd0);
        checkOutput("midRst_count", 32'(byteCount), 32'd0);
        checkOutput("midRst_timeout", 32'(timeoutError), 32'd0);
        sendBytes(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        expectWord("postRst", 32'hDDCCBBAA);

        $display("[TB] MSB-first ordering");
        sendBytes(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        checkOutput("msb_readyLow", 32'(byteReadyMsb), 32'd0);
        checkOutput("msb_noEarlyPulse", 32'(enableOutMsb), 32'd0);
        tick();
        checkOutput("msb_pulse", 32'(enableOutMsb), 32'd1);
        checkOutput("msb_value", valueOutMsb, 32'hDEADBEEF);
        checkOutput("msb_lsbTwin", valueOut, 32'hEFBEADDE);
        tick();
        checkOutput("msb_pulseEnd", 32'(enableOutMsb), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
